// File: rtl/pattern_seq_gen.sv
// pattern_seq_gen: serial pattern generator.
// A small table of PAT_W-bit patterns is indexed by sel at start; the chosen
// pattern is copied into a private shift register and emitted MSB first on
// 'pattern' with 'valid' high for PAT_W cycles. Optional back-to-back repeat
// (rep), abort on en=0, and a one-cycle 'done' pulse on normal completion.
// Optional feature macro: PATGEN_PROG_EN -- when defined, the table is
// writable through wr_en/wr_addr/wr_data; otherwise the table is constant
// and the write ports are ignored.
module pattern_seq_gen #(
    parameter int PAT_W = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             rep,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [PAT_W-1:0] wr_data,
    output logic             pattern,
    output logic             valid,
    output logic             done
);

    localparam int NSLOT = 1 << SEL_W;
    localparam int CNT_W = $clog2(PAT_W);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Reset/constant table contents: slots 0..3 hold 1100,1101,1110,1111
    // left-aligned in PAT_W (zero-filled below, or truncated to the MSBs).
    function automatic logic [PAT_W-1:0] slot_init(input int idx);
        logic [31:0] full_v;
        if (idx >= 0 && idx < 4) begin
            full_v = {2'b11, 2'(idx), 28'd0};
        end else begin
            full_v = 32'd0;
        end
        return full_v[31 -: PAT_W];
    endfunction

    logic [PAT_W-1:0] table_s [NSLOT];

`ifdef PATGEN_PROG_EN
    logic [PAT_W-1:0] table_q [NSLOT];
    logic [PAT_W-1:0] table_d [NSLOT];

    // Next table contents: the addressed slot takes wr_data on a write strobe.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            table_d[i] = (wr_en && (wr_addr == SEL_W'(i))) ? wr_data : table_q[i];
        end
    end

    // Table storage; reset restores the default contents and beats any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                table_q[i] <= slot_init(i);
            end
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // Starts read the registered table, so a same-cycle write is seen next time.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            table_s[i] = table_q[i];
        end
    end
`else
    logic unused_wr_s;
    assign unused_wr_s = ^{wr_en, wr_addr, wr_data};

    // Constant table: write ports have no effect in this build.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            table_s[i] = slot_init(i);
        end
    end
`endif

    logic [1:0]       state_q,   state_d;
    logic [PAT_W-1:0] sr_q,      sr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             pattern_q, pattern_d;
    logic             valid_q,   valid_d;
    logic             done_q,    done_d;
    logic [PAT_W-1:0] load_s;

    assign load_s = table_s[sel];

    // Sequencer: start/shift/repeat/finish/abort decisions and output values.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        pattern_d = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    pattern_d = load_s[PAT_W-1];
                    sr_d      = load_s << 1;
                    cnt_d     = CNT_LAST;
                    valid_d   = 1'b1;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!en) begin
                    // Abort wins over completion: no done pulse.
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else if (cnt_q != CNT_ZERO) begin
                    pattern_d = sr_q[PAT_W-1];
                    sr_d      = sr_q << 1;
                    cnt_d     = cnt_q - CNT_ONE;
                    valid_d   = 1'b1;
                end else if (rep) begin
                    // Reload with sel resampled, no gap cycle.
                    pattern_d = load_s[PAT_W-1];
                    sr_d      = load_s << 1;
                    cnt_d     = CNT_LAST;
                    valid_d   = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= {PAT_W{1'b0}};
            cnt_q     <= CNT_ZERO;
            pattern_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign pattern = pattern_q;
    assign valid   = valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Testbench for pattern_seq_gen (PAT_W=4 main instance, PAT_W=8 second
// instance sharing the control inputs). Expected values come from a table
// model and the serial-pattern rules, not from the design.
module tb_pattern_seq_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       rep = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       pattern, valid, done;

    logic       wr_en8 = 1'b0;
    logic [1:0] wr_addr8 = 2'd0;
    logic [7:0] wr_data8 = 8'd0;
    logic       pattern8, valid8, done8;

    int checks = 0;
    int errors = 0;

    logic [3:0] tbl [4];

    pattern_seq_gen #(.PAT_W(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .rep(rep),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pattern(pattern), .valid(valid), .done(done)
    );

    pattern_seq_gen #(.PAT_W(8), .SEL_W(2)) dut8 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .rep(rep),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .pattern(pattern8), .valid(valid8), .done(done8)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] init4(input int i);
        logic [3:0] v;
        v = 4'b0000;
        if (i < 4) v = {2'b11, i[1:0]};
        return v;
    endfunction

    // Advance one edge, sample 1ns later, and update the table model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 4; i++) tbl[i] = init4(i);
        end else begin
`ifdef PATGEN_PROG_EN
            if (wr_en) tbl[wr_addr] = wr_data;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'd0;
        tick();
        checks++;
        if ({pattern, valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 000", {pattern, valid, done});
        end
        checks++;
        if ({pattern8, valid8, done8} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs8 got %b exp 000", {pattern8, valid8, done8});
        end
        en = 1'b0; wr_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({pattern, valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp 000", {pattern, valid, done});
        end
    endtask

    task automatic test_basic();
        logic [3:0] p;
        int nh;
        for (int s = 0; s < 4; s++) begin
            en = 1'b1; sel = 2'(s); rep = 1'($urandom);
            p = tbl[s];
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if ({valid, pattern, done} !== {1'b1, p[3-i], 1'b0}) begin
                    errors++;
                    $display("FAIL basic_bit s=%0d i=%0d got v/p/d=%b exp %b", s, i,
                             {valid, pattern, done}, {1'b1, p[3-i], 1'b0});
                end
                sel = 2'($urandom);
                rep = (i == 3) ? 1'b0 : 1'($urandom);
            end
            tick();
            checks++;
            if ({valid, pattern, done} !== 3'b001) begin
                errors++;
                $display("FAIL basic_done s=%0d got v/p/d=%b exp 001", s, {valid, pattern, done});
            end
            nh = $urandom_range(0, 3);
            for (int h = 0; h < nh; h++) begin
                tick();
                checks++;
                if ({valid, pattern, done} !== 3'b000) begin
                    errors++;
                    $display("FAIL basic_hold s=%0d got v/p/d=%b exp 000", s, {valid, pattern, done});
                end
            end
            en = 1'b0;
            tick();
            checks++;
            if ({valid, pattern, done} !== 3'b000) begin
                errors++;
                $display("FAIL basic_idle s=%0d got v/p/d=%b exp 000", s, {valid, pattern, done});
            end
        end
    endtask

    task automatic test_repeat();
        logic [3:0] p;
        en = 1'b1; sel = 2'd1; rep = 1'b1;
        p = tbl[1];
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({valid, pattern, done} !== {1'b1, p[3-(i%4)], 1'b0}) begin
                errors++;
                $display("FAIL repeat_bit i=%0d got v/p/d=%b exp %b", i,
                         {valid, pattern, done}, {1'b1, p[3-(i%4)], 1'b0});
            end
            if (i == 12) rep = 1'b0;
        end
        tick();
        checks++;
        if ({valid, pattern, done} !== 3'b001) begin
            errors++;
            $display("FAIL repeat_done got v/p/d=%b exp 001", {valid, pattern, done});
        end
        tick();
        checks++;
        if ({valid, pattern, done} !== 3'b000) begin
            errors++;
            $display("FAIL repeat_hold got v/p/d=%b exp 000", {valid, pattern, done});
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] p;
        int np, s;
        for (int r = 0; r < 20; r++) begin
            en = 1'b1; sel = 2'($urandom); rep = 1'($urandom);
            wr_en = 1'($urandom); wr_addr = 2'($urandom); wr_data = 4'($urandom);
            p = tbl[sel];
            s = int'(sel);
            np = $urandom_range(1, 3);
            for (int k = 0; k < np; k++) begin
                for (int b = 0; b < 4; b++) begin
                    tick();
                    checks++;
                    if ({valid, pattern, done} !== {1'b1, p[3-b], 1'b0}) begin
                        errors++;
                        $display("FAIL random_bit r=%0d k=%0d b=%0d slot=%0d got v/p/d=%b exp %b",
                                 r, k, b, s, {valid, pattern, done}, {1'b1, p[3-b], 1'b0});
                    end
                    sel = 2'($urandom);
                    wr_en = 1'($urandom); wr_addr = 2'($urandom); wr_data = 4'($urandom);
                    if (b == 3) begin
                        rep = (k < np - 1) ? 1'b1 : 1'b0;
                        p = tbl[sel];
                        s = int'(sel);
                    end else begin
                        rep = 1'($urandom);
                    end
                end
            end
            tick();
            checks++;
            if ({valid, pattern, done} !== 3'b001) begin
                errors++;
                $display("FAIL random_done r=%0d got v/p/d=%b exp 001", r, {valid, pattern, done});
            end
            wr_en = 1'b0;
            en = 1'b0;
            tick();
            checks++;
            if ({valid, pattern, done} !== 3'b000) begin
                errors++;
                $display("FAIL random_idle r=%0d got v/p/d=%b exp 000", r, {valid, pattern, done});
            end
        end
    endtask

    task automatic test_abort();
        logic [3:0] p;
        en = 1'b1; sel = 2'd3; rep = 1'b0;
        p = tbl[3];
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({valid, pattern} !== {1'b1, p[3-i]}) begin
                errors++;
                $display("FAIL abort_pre i=%0d got v/p=%b exp %b", i, {valid, pattern}, {1'b1, p[3-i]});
            end
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({valid, pattern, done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_off i=%0d got v/p/d=%b exp 000", i, {valid, pattern, done});
            end
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({valid, pattern, done} !== {1'b1, p[3-i], 1'b0}) begin
                errors++;
                $display("FAIL abort_restart i=%0d got v/p/d=%b exp %b", i,
                         {valid, pattern, done}, {1'b1, p[3-i], 1'b0});
            end
        end
        tick();
        checks++;
        if ({valid, pattern, done} !== 3'b001) begin
            errors++;
            $display("FAIL abort_restart_done got v/p/d=%b exp 001", {valid, pattern, done});
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [3:0] p;
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'b1010;
        tick();
        wr_en = 1'b0;
        for (int run = 0; run < 2; run++) begin
            en = 1'b1; sel = 2'd2; rep = 1'b0;
            p = tbl[2];
            // Same-cycle write to the slot being started must not affect this run.
            wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if ({valid, pattern} !== {1'b1, p[3-i]}) begin
                    errors++;
                    $display("FAIL write_bit run=%0d i=%0d got v/p=%b exp %b", run, i,
                             {valid, pattern}, {1'b1, p[3-i]});
                end
                wr_data = 4'($urandom);
            end
            wr_en = 1'b0;
            tick();
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL write_done run=%0d got %b exp 1", run, done);
            end
            en = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p8;
        logic [3:0] p;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        p = tbl[0];
        p8 = {init4(0), 4'b0000};
        en = 1'b1; sel = 2'd0; rep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid, pattern, valid8, pattern8} !== {1'b1, p[3-i], 1'b1, p8[7-i]}) begin
                errors++;
                $display("FAIL rstmid_pre i=%0d got %b exp %b", i,
                         {valid, pattern, valid8, pattern8}, {1'b1, p[3-i], 1'b1, p8[7-i]});
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({pattern, valid, done, pattern8, valid8, done8} !== 6'b000000) begin
            errors++;
            $display("FAIL rstmid_outputs got %b exp 000000",
                     {pattern, valid, done, pattern8, valid8, done8});
        end
        rst = 1'b0; en = 1'b0;
        tick();
        checks++;
        if ({done, done8} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_nodone got %b exp 00", {done, done8});
        end
        en = 1'b1; sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({valid8, pattern8, done8} !== {1'b1, p8[7-i], 1'b0}) begin
                errors++;
                $display("FAIL w8_bit i=%0d got v/p/d=%b exp %b", i,
                         {valid8, pattern8, done8}, {1'b1, p8[7-i], 1'b0});
            end
        end
        tick();
        checks++;
        if ({valid8, pattern8, done8} !== 3'b001) begin
            errors++;
            $display("FAIL w8_done got v/p/d=%b exp 001", {valid8, pattern8, done8});
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tbl[i] = init4(i);
        #1;
        test_reset();
        test_basic();
        test_repeat();
        test_abort();
        test_write();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pattern_seq_gen.md
PATTERN_SEQ_GEN -- requirements
Module: pattern_seq_gen

Interface
REQ-001 Parameter PAT_W, default 4, sets the pattern length in bits (legal range 2..32).
REQ-002 Parameter SEL_W, default 2, sets the select width; the table holds 2**SEL_W slots.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  start/hold request.
REQ-006 sel  input  SEL_W  slot select, sampled only at start.
REQ-007 rep  input  1  repeat mode, sampled on the last-bit cycle.
REQ-008 wr_en  input  1  table write strobe.
REQ-009 wr_addr  input  SEL_W  table write slot.
REQ-010 wr_data  input  PAT_W  table write data.
REQ-011 pattern  output  1  serial pattern bit, MSB first, registered.
REQ-012 valid  output  1  pattern qualifier, registered.
REQ-013 done  output  1  one-cycle pulse after the final bit of a non-repeated pattern.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and HOLD, and reset to IDLE.
REQ-015 Start: at an edge in IDLE with en=1, load slot[sel] into a PAT_W shift register, drive pattern=slot[sel][PAT_W-1] and valid=1, load bit counter=PAT_W-1, and enter SHIFT; valid therefore rises one cycle after en is first seen.
REQ-016 SHIFT: each edge with en=1 and counter>0 SHALL present the next lower bit and decrement the counter; valid stays 1 for exactly PAT_W consecutive cycles per pattern.
REQ-017 At an edge in SHIFT with counter=0, en=1 and rep=1, the block SHALL reload slot[sel] (sel resampled) with no gap cycle, and valid stays 1.
REQ-018 At an edge in SHIFT with counter=0 and rep=0, the block SHALL drive valid=0 and pattern=0, pulse done=1 for one cycle, and enter HOLD.
REQ-019 HOLD: stay while en=1 and move to IDLE on the first edge with en=0; a new start therefore requires en to drop for at least one cycle.
REQ-020 Abort: en=0 at any edge in SHIFT SHALL force valid=0 and pattern=0 and move to IDLE, with no done pulse.
REQ-021 pattern SHALL be 0 whenever valid=0.
REQ-022 Table writes take effect at the edge where wr_en=1, in any state; an active pattern is unaffected because it shifts from its private copy, and a write to the slot being started in the same cycle is seen by the next start only.
REQ-023 Table reset contents: slots 0..3 = 4'b1100, 4'b1101, 4'b1110, 4'b1111 left-aligned in PAT_W (zero-filled LSBs; truncated to MSBs if PAT_W<4); all other slots = 0.
REQ-024 Counter width = clog2(PAT_W); no arithmetic overflow is permitted.

Reset
REQ-025 With rst=1 at an edge, the block SHALL apply state=IDLE, pattern=0, valid=0, done=0, counter=0 and the REQ-023 table; rst takes priority over en and wr_en.
REQ-026 Reset mid-pattern SHALL terminate output in the same edge, with no done pulse.

Configuration
REQ-027 Macro PATGEN_PROG_EN defined: the table is writable per REQ-022.
REQ-028 PATGEN_PROG_EN undefined: the table is constant at the REQ-023 values, and wr_en, wr_addr and wr_data are ignored (the ports remain present).

Verification (PAT_W=4, SEL_W=2 unless stated)
REQ-029 Reset, then en=1 with sel=0,1,2,3 in turn (rep=0, en low between runs) -> serial output 1100, 1101, 1110, 1111; valid high 4 cycles each; done pulses once per run.
REQ-030 With PATGEN_PROG_EN defined, write slot2=4'b1010, then start sel=2 -> 1010; a write to slot2 during the shift leaves the running pattern unchanged.
REQ-031 rep=1, sel=1, en held high for 12 cycles -> 110111011101 with valid continuous and no done pulse; then rep=0 -> one more 1101, done pulse, enter HOLD.
REQ-032 en dropped after the 2nd bit of sel=3 -> valid=0 and pattern=0 on the next edge, no done pulse, and a restart produces the full 1111.
REQ-033 rst=1 during the 3rd bit -> all outputs 0 the next cycle; with PAT_W=8, sel=0 -> 11000000.
